// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, field widths, FSM states.
package alu_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ALUOP_W   = 3;
    localparam int unsigned SHIFTOP_W = 2;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_FORWARD = 3'b000,
        ALUOP_ADD     = 3'b001,
        ALUOP_AND     = 3'b010,
        ALUOP_OR      = 3'b011,
        ALUOP_SHIFT   = 3'b100,
        ALUOP_MULT    = 3'b101,
        ALUOP_RSVD6   = 3'b110,
        ALUOP_RSVD7   = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Shift and multiply take the long ALU path.
    function automatic logic is_slow_op(input logic [ALUOP_W-1:0] op);
        return (op == ALUOP_SHIFT) || (op == ALUOP_MULT);
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Two-requester grant selection with round-robin pointer.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on contention.
module alu_arb_grant
    import alu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_ready0,
    output logic o_ready1,
    output logic o_winner
);

    logic r_last;
    logic w_winner;

    // Pick the winner; a lone valid requester always wins.
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_winner = !i_valid0 && i_valid1;
`else
        if (i_valid0 && i_valid1) begin
            w_winner = ~r_last;
        end else begin
            w_winner = i_valid1;
        end
`endif
        o_ready0 = i_idle && i_valid0 && !w_winner;
        o_ready1 = i_idle && i_valid1 &&  w_winner;
        o_winner = w_winner;
    end

    // Remember the last granted requester; reset value lets requester 0 win first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (o_ready0 || o_ready1) begin
            r_last <= w_winner;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle ALU and returns results.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 wins every contended grant.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned LAT_FAST = 1,
    parameter int unsigned LAT_SLOW = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ0_VALID,
    output logic                 REQ0_READY,
    input  logic [ALUOP_W-1:0]   REQ0_ALUOP,
    input  logic [SHIFTOP_W-1:0] REQ0_SHIFTOP,
    input  logic [DATA_W-1:0]    REQ0_DATA1,
    input  logic [DATA_W-1:0]    REQ0_DATA2,
    input  logic                 REQ1_VALID,
    output logic                 REQ1_READY,
    input  logic [ALUOP_W-1:0]   REQ1_ALUOP,
    input  logic [SHIFTOP_W-1:0] REQ1_SHIFTOP,
    input  logic [DATA_W-1:0]    REQ1_DATA1,
    input  logic [DATA_W-1:0]    REQ1_DATA2,
    output logic                 RESP0_VALID,
    output logic [DATA_W-1:0]    RESP0_RESULT,
    output logic                 RESP0_ZERO,
    output logic                 RESP1_VALID,
    output logic [DATA_W-1:0]    RESP1_RESULT,
    output logic                 RESP1_ZERO,
    output logic [DATA_W-1:0]    ALU_DATA1,
    output logic [DATA_W-1:0]    ALU_DATA2,
    output logic [ALUOP_W-1:0]   ALU_ALUOP,
    output logic [SHIFTOP_W-1:0] ALU_SHIFTOP,
    input  logic [DATA_W-1:0]    ALU_RESULT,
    input  logic                 ALU_ZERO,
    output logic                 BUSY,
    output logic                 OWNER
);

    localparam int unsigned LAT_MAX = (LAT_SLOW > LAT_FAST) ? LAT_SLOW : LAT_FAST;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_owner;
    logic [DATA_W-1:0]      r_data1;
    logic [DATA_W-1:0]      r_data2;
    logic [ALUOP_W-1:0]     r_aluop;
    logic [SHIFTOP_W-1:0]   r_shiftop;
    logic [DATA_W-1:0]      r_res0;
    logic [DATA_W-1:0]      r_res1;
    logic                   r_zero0;
    logic                   r_zero1;
    logic                   w_idle;
    logic                   w_winner;
    logic                   w_accept;
    logic                   w_exec_done;
    logic [ALUOP_W-1:0]     w_sel_aluop;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = REQ0_READY || REQ1_READY;
    assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == '0);
    assign w_sel_aluop = w_winner ? REQ1_ALUOP : REQ0_ALUOP;

    alu_arb_grant u_grant (
        .i_clk    (CLK),
        .i_rst    (RESET),
        .i_idle   (w_idle),
        .i_valid0 (REQ0_VALID),
        .i_valid1 (REQ1_VALID),
        .o_ready0 (REQ0_READY),
        .o_ready1 (REQ1_READY),
        .o_winner (w_winner)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept -> run for lat cycles -> one response cycle -> idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the granted operation onto the ALU and load the wait counter with lat-1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_aluop   <= '0;
            r_shiftop <= '0;
        end else if (w_accept) begin
            r_owner   <= w_winner;
            r_aluop   <= w_sel_aluop;
            r_shiftop <= w_winner ? REQ1_SHIFTOP : REQ0_SHIFTOP;
            r_data1   <= w_winner ? REQ1_DATA1   : REQ0_DATA1;
            r_data2   <= w_winner ? REQ1_DATA2   : REQ0_DATA2;
            r_cnt     <= is_slow_op(w_sel_aluop) ? CNT_W'(LAT_SLOW - 1)
                                                 : CNT_W'(LAT_FAST - 1);
        end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture the ALU outputs into the owner's response registers on the last EXEC edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_res0  <= '0;
            r_res1  <= '0;
            r_zero0 <= 1'b0;
            r_zero1 <= 1'b0;
        end else if (w_exec_done) begin
            if (r_owner) begin
                r_res1  <= ALU_RESULT;
                r_zero1 <= ALU_ZERO;
            end else begin
                r_res0  <= ALU_RESULT;
                r_zero0 <= ALU_ZERO;
            end
        end
    end

    assign RESP0_VALID  = (r_state == ST_RESP) && !r_owner;
    assign RESP1_VALID  = (r_state == ST_RESP) &&  r_owner;
    assign RESP0_RESULT = r_res0;
    assign RESP0_ZERO   = r_zero0;
    assign RESP1_RESULT = r_res1;
    assign RESP1_ZERO   = r_zero1;
    assign ALU_DATA1    = r_data1;
    assign ALU_DATA2    = r_data2;
    assign ALU_ALUOP    = r_aluop;
    assign ALU_SHIFTOP  = r_shiftop;
    assign BUSY         = !w_idle;
    assign OWNER        = r_owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Honours ALU_ARB_FIXED_PRIO_EN for the contended-grant expectations.
module tb_alu_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [2:0] REQ0_ALUOP, REQ1_ALUOP;
    logic [1:0] REQ0_SHIFTOP, REQ1_SHIFTOP;
    logic [7:0] REQ0_DATA1, REQ0_DATA2, REQ1_DATA1, REQ1_DATA2;
    logic       RESP0_VALID, RESP0_ZERO, RESP1_VALID, RESP1_ZERO;
    logic [7:0] RESP0_RESULT, RESP1_RESULT;
    logic [7:0] ALU_DATA1, ALU_DATA2, ALU_RESULT;
    logic [2:0] ALU_ALUOP;
    logic [1:0] ALU_SHIFTOP;
    logic       ALU_ZERO, BUSY, OWNER;

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   both_ready = 0;
    int   ready_nv = 0;
    int   ready1_cnt = 0;
    bit   grant_order[4];

    alu_arbiter #(.LAT_FAST(1), .LAT_SLOW(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_ALUOP(REQ0_ALUOP),
        .REQ0_SHIFTOP(REQ0_SHIFTOP), .REQ0_DATA1(REQ0_DATA1), .REQ0_DATA2(REQ0_DATA2),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_ALUOP(REQ1_ALUOP),
        .REQ1_SHIFTOP(REQ1_SHIFTOP), .REQ1_DATA1(REQ1_DATA1), .REQ1_DATA2(REQ1_DATA2),
        .RESP0_VALID(RESP0_VALID), .RESP0_RESULT(RESP0_RESULT), .RESP0_ZERO(RESP0_ZERO),
        .RESP1_VALID(RESP1_VALID), .RESP1_RESULT(RESP1_RESULT), .RESP1_ZERO(RESP1_ZERO),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_ALUOP(ALU_ALUOP),
        .ALU_SHIFTOP(ALU_SHIFTOP), .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
        .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural shared ALU.
    always_comb begin
        case (ALU_ALUOP)
            3'b000: ALU_RESULT = ALU_DATA1;
            3'b001: ALU_RESULT = ALU_DATA1 + ALU_DATA2;
            3'b010: ALU_RESULT = ALU_DATA1 & ALU_DATA2;
            3'b011: ALU_RESULT = ALU_DATA1 | ALU_DATA2;
            3'b100: begin
                case (ALU_SHIFTOP)
                    2'b00:   ALU_RESULT = ALU_DATA1 << ALU_DATA2[2:0];
                    2'b01:   ALU_RESULT = ALU_DATA1 >> ALU_DATA2[2:0];
                    default: ALU_RESULT = {ALU_DATA1[6:0], ALU_DATA1[7]};
                endcase
            end
            3'b101:  ALU_RESULT = ALU_DATA1 * ALU_DATA2;
            default: ALU_RESULT = 8'h00;
        endcase
        ALU_ZERO = (ALU_RESULT == 8'h00);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_exp(input bit n, input logic [7:0] res, input logic z, input int c);
        exp_t e;
        e.res = res;
        e.z   = z;
        e.cyc = c;
        if (n) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    // Monitor: protocol counters and scoreboard pops on every response pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            if (REQ0_READY && REQ1_READY) both_ready++;
            if ((REQ0_READY && !REQ0_VALID) || (REQ1_READY && !REQ1_VALID)) ready_nv++;
            if (REQ1_READY) ready1_cnt++;
            if (RESP0_VALID) begin
                if (q0.size() == 0) fail_now("resp0_unexpected_pulse");
                else begin
                    e = q0.pop_front();
                    check("resp0_result", RESP0_RESULT, e.res);
                    check("resp0_zero",   RESP0_ZERO,   e.z);
                    check("resp0_cycle",  cyc,          e.cyc);
                end
            end
            if (RESP1_VALID) begin
                if (q1.size() == 0) fail_now("resp1_unexpected_pulse");
                else begin
                    e = q1.pop_front();
                    check("resp1_result", RESP1_RESULT, e.res);
                    check("resp1_zero",   RESP1_ZERO,   e.z);
                    check("resp1_cycle",  cyc,          e.cyc);
                end
            end
        end
    end

    task automatic issue(input bit n, input logic [2:0] op, input logic [1:0] sop,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] er, input logic ez, input bit expect_resp);
        int lat;
        int t;
        bit got;
        lat = (op == 3'b100 || op == 3'b101) ? 3 : 1;
        got = 1'b0;
        @(posedge CLK); #1;
        if (n) begin
            REQ1_ALUOP = op; REQ1_SHIFTOP = sop; REQ1_DATA1 = d1; REQ1_DATA2 = d2; REQ1_VALID = 1'b1;
        end else begin
            REQ0_ALUOP = op; REQ0_SHIFTOP = sop; REQ0_DATA1 = d1; REQ0_DATA2 = d2; REQ0_VALID = 1'b1;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = n ? REQ1_READY : REQ0_READY;
        end
        if (!got) begin
            fail_now("accept_timeout");
            REQ0_VALID = 1'b0;
            REQ1_VALID = 1'b0;
            return;
        end
        t = cyc;
        if (expect_resp) push_exp(n, er, ez, t + lat + 1);
        @(posedge CLK); #1;
        // Drop the request and scribble its fields; the ALU drive must not follow.
        if (n) begin
            REQ1_VALID = 1'b0; REQ1_DATA1 = ~d1; REQ1_DATA2 = ~d2; REQ1_ALUOP = ~op;
        end else begin
            REQ0_VALID = 1'b0; REQ0_DATA1 = ~d1; REQ0_DATA2 = ~d2; REQ0_ALUOP = ~op;
        end
        #1;
        check("alu_aluop",   ALU_ALUOP,   op);
        check("alu_shiftop", ALU_SHIFTOP, sop);
        check("alu_data1",   ALU_DATA1,   d1);
        check("alu_data2",   ALU_DATA2,   d2);
        check("busy_exec",   BUSY,        1'b1);
        check("owner",       OWNER,       n);
    endtask

    // Wait until all expected responses are seen and the arbiter is idle.
    task automatic settle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            done = (q0.size() == 0) && (q1.size() == 0) && !BUSY;
        end
        if (!done) begin
            fail_now("settle_timeout");
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic contend();
        int g;
        int last_t;
        bit w;
        g = 0;
        last_t = 0;
        @(posedge CLK); #1;
        REQ0_ALUOP = 3'b101; REQ0_SHIFTOP = 2'b00; REQ0_DATA1 = 8'h04; REQ0_DATA2 = 8'h03;
        REQ1_ALUOP = 3'b101; REQ1_SHIFTOP = 2'b00; REQ1_DATA1 = 8'h04; REQ1_DATA2 = 8'h03;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        for (int i = 0; i < 100 && g < 4; i++) begin
            @(negedge CLK);
            if (REQ0_READY || REQ1_READY) begin
                w = REQ1_READY;
                grant_order[g] = w;
                if (g > 0) check("contend_accept_spacing", cyc - last_t, 5);
                last_t = cyc;
                push_exp(w, 8'h0C, 1'b0, cyc + 4);
                g++;
            end
        end
        if (g < 4) fail_now("contend_grant_timeout");
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int r1s;
        int t0;
        int t1;
        bit got;
        RESET = 1'b1;
        REQ0_VALID = 1'b0; REQ0_ALUOP = '0; REQ0_SHIFTOP = '0; REQ0_DATA1 = '0; REQ0_DATA2 = '0;
        REQ1_VALID = 1'b0; REQ1_ALUOP = '0; REQ1_SHIFTOP = '0; REQ1_DATA1 = '0; REQ1_DATA2 = '0;
        #2;
        check("rst_resp_valid", {RESP0_VALID, RESP1_VALID}, 2'b00);
        check("rst_resp_data",  {RESP0_RESULT, RESP0_ZERO, RESP1_RESULT, RESP1_ZERO}, 18'h0);
        check("rst_alu",        {ALU_DATA1, ALU_DATA2, ALU_ALUOP, ALU_SHIFTOP}, 21'h0);
        check("rst_busy_owner", {BUSY, OWNER}, 2'b00);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // Requester 0 alone: fast and slow ops, plus a withdrawn request from 1.
        r1s = ready1_cnt;
        issue(1'b0, 3'b001, 2'b00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b1);
        settle();
        issue(1'b0, 3'b100, 2'b00, 8'h81, 8'h01, 8'h02, 1'b0, 1'b1);
        REQ1_ALUOP = 3'b001; REQ1_DATA1 = 8'h11; REQ1_DATA2 = 8'h22; REQ1_VALID = 1'b1;
        @(posedge CLK); #1 REQ1_VALID = 1'b0;
        settle();
        issue(1'b0, 3'b010, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1);
        settle();
        check("req1_ready_while_req0_only", ready1_cnt - r1s, 0);

        // Requester 1: zero result, reserved op; requester 0 outputs must hold.
        issue(1'b1, 3'b000, 2'b00, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b1);
        settle();
        check("resp0_hold_result", RESP0_RESULT, 8'h30);
        check("resp0_hold_zero",   RESP0_ZERO,   1'b0);
        check("resp1_hold_result", RESP1_RESULT, 8'h00);
        check("resp1_hold_zero",   RESP1_ZERO,   1'b1);
        issue(1'b1, 3'b110, 2'b11, 8'h33, 8'h44, 8'h00, 1'b1, 1'b1);
        settle();

        // Both valid continuously for four MULT operations.
        r1s = ready1_cnt;
        contend();
        settle();
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("contend_grant_order", {grant_order[0], grant_order[1], grant_order[2], grant_order[3]}, 4'b0000);
        check("contend_ready1_count", ready1_cnt - r1s, 0);
`else
        check("contend_grant_order", {grant_order[0], grant_order[1], grant_order[2], grant_order[3]}, 4'b0101);
        check("contend_ready1_count", ready1_cnt - r1s, 2);
`endif

        // Reset during a MULT at T+2: everything clears at once, no response follows.
        issue(1'b0, 3'b101, 2'b00, 8'h04, 8'h03, 8'h00, 1'b0, 1'b0);
        @(posedge CLK); #1;
        check("pre_rst_busy", BUSY, 1'b1);
        #1 RESET = 1'b1;
        #1;
        check("mid_rst_resp_valid", {RESP0_VALID, RESP1_VALID}, 2'b00);
        check("mid_rst_resp_data",  {RESP0_RESULT, RESP0_ZERO, RESP1_RESULT, RESP1_ZERO}, 18'h0);
        check("mid_rst_alu",        {ALU_DATA1, ALU_DATA2, ALU_ALUOP, ALU_SHIFTOP}, 21'h0);
        check("mid_rst_busy_owner", {BUSY, OWNER}, 2'b00);
        @(posedge CLK); #1 RESET = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("post_rst_idle", BUSY, 1'b0);

        // First contended grant after reset goes to requester 0.
        REQ0_ALUOP = 3'b001; REQ0_SHIFTOP = 2'b00; REQ0_DATA1 = 8'h01; REQ0_DATA2 = 8'h01;
        REQ1_ALUOP = 3'b001; REQ1_SHIFTOP = 2'b00; REQ1_DATA1 = 8'h10; REQ1_DATA2 = 8'h20;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        @(negedge CLK);
        check("post_rst_ready0", REQ0_READY, 1'b1);
        check("post_rst_ready1", REQ1_READY, 1'b0);
        t0 = cyc;
        push_exp(1'b0, 8'h02, 1'b0, t0 + 2);
        @(posedge CLK); #1 REQ0_VALID = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            got = REQ1_READY;
        end
        if (!got) fail_now("post_rst_req1_timeout");
        else begin
            t1 = cyc;
            check("post_rst_next_accept", t1 - t0, 3);
            push_exp(1'b1, 8'h30, 1'b0, t1 + 2);
        end
        @(posedge CLK); #1 REQ1_VALID = 1'b0;
        settle();

        check("ready_both_high_count", both_ready, 0);
        check("ready_without_valid_count", ready_nv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LAT_FAST, default 1: ALU cycles for ALUOP 000-011, 110, 111.
REQ-002 SHALL have parameter LAT_SLOW, default 3: ALU cycles for ALUOP 100 (shift) and 101 (multiply).
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports REQn_VALID  input  1  requester n (n=0,1) has an operation pending.
REQ-006 SHALL have ports REQn_READY  output  1  arbiter accepts requester n's operation this cycle.
REQ-007 SHALL have ports REQn_ALUOP  input  3, REQn_SHIFTOP  input  2, REQn_DATA1  input  8, REQn_DATA2  input  8: operation fields.
REQ-008 SHALL have ports RESPn_VALID  output  1  one-cycle completion pulse to requester n.
REQ-009 SHALL have ports RESPn_RESULT  output  8 and RESPn_ZERO  output  1: captured ALU result and zero flag.
REQ-010 SHALL have ports ALU_DATA1  output  8, ALU_DATA2  output  8, ALU_ALUOP  output  3, ALU_SHIFTOP  output  2: drive the shared ALU.
REQ-011 SHALL have ports ALU_RESULT  input  8 and ALU_ZERO  input  1: ALU outputs.
REQ-012 SHALL have ports BUSY  output  1 (state not IDLE) and OWNER  output  1 (requester currently served).

Function
REQ-013 SHALL implement states IDLE, EXEC, RESP; IDLE->EXEC on acceptance, EXEC->RESP when wait counter reaches zero, RESP->IDLE unconditionally.
REQ-014 SHALL assert REQn_READY combinationally only in IDLE, only for the arbitration winner, and only when REQn_VALID is high; at most one READY high per cycle.
REQ-015 SHALL, when only one requester is valid in IDLE, grant it regardless of pointer.
REQ-016 SHALL, when both valid in IDLE, grant the requester not granted last (round-robin pointer), updating the pointer on every acceptance.
REQ-017 SHALL, on acceptance at cycle T, register ALUOP/SHIFTOP/DATA1/DATA2 onto ALU_* at T+1 and hold them unchanged until the next acceptance.
REQ-018 SHALL select lat = LAT_SLOW for ALUOP 100/101, else LAT_FAST; EXEC lasts exactly lat cycles (T+1..T+lat).
REQ-019 SHALL capture ALU_RESULT/ALU_ZERO at the rising edge ending cycle T+lat and present them on the owner's RESPn_RESULT/RESPn_ZERO with RESPn_VALID high during cycle T+lat+1 only.
REQ-020 SHALL hold RESPn_RESULT/RESPn_ZERO stable after the pulse until that requester's next response; the non-owner's RESP outputs SHALL not change.
REQ-021 SHALL give no response backpressure; requester must consume the pulse.
REQ-022 SHALL pass reserved ALUOP 110/111 to the ALU unchanged and return whatever the ALU produces (expected 0x00, ZERO=1).
REQ-023 SHALL ignore REQn_VALID changes and field changes while not in IDLE; earliest next acceptance is cycle T+lat+2.
REQ-024 SHALL treat a VALID deasserted before READY as a withdrawn request (no state change).

Reset
REQ-025 SHALL, on RESET asserted at any time, immediately force IDLE, all RESPn_VALID=0, RESPn_RESULT=0x00, RESPn_ZERO=0, ALU_* outputs=0, BUSY=0, OWNER=0, wait counter=0.
REQ-026 SHALL set the round-robin pointer on reset so requester 0 wins the first contended grant.
REQ-027 SHALL discard an in-flight operation on reset; no response pulse SHALL follow for it.

Configuration
REQ-028 SHALL, with macro ALU_ARB_FIXED_PRIO_EN defined, grant requester 0 whenever both are valid (pointer unused); without it, round-robin per REQ-016.

Structure
REQ-029 SHALL take ALUOP codes (FORWARD 000, ADD 001, AND 010, OR 011, SHIFT 100, MULT 101), SHIFTOP width and FSM state encodings from shared package alu_pkg.
REQ-030 SHALL place grant selection and pointer in sub-module alu_arb_grant; FSM, counter and capture registers remain in alu_arbiter.

Verification
REQ-031 Req0 only, ADD 0x05+0x03 at T -> RESP0_VALID at T+2, RESULT 0x08, ZERO 0, READY1 never high.
REQ-032 Both valid continuously, MULT 0x04*0x03 each -> grants alternate 0,1,0,1; RESP pulse at T+4 each; next accept at T+5.
REQ-033 Req1 FORWARD 0x00 -> RESP1_RESULT 0x00, ZERO 1; RESP0 outputs unchanged.
REQ-034 RESET asserted at T+2 of a MULT -> all outputs 0 same cycle, no RESP pulse, first contended grant after release to requester 0.
REQ-035 ALU_ARB_FIXED_PRIO_EN defined, both valid for 4 operations -> requester 0 granted all 4, REQ1_READY never high.
